spi_byte_slave: RTL
===================

# spi_byte_slave

SPI slave front end that turns the host's serial link into a byte-level handshake for the miner control logic. It oversamples SCK/MOSI/SSEL in the system clock domain and pulses `byte_received` with each completed MOSI byte. It also shifts out the byte presented on `data_to_send` on MISO. It sits between the board SPI pins and the miner controller, which consumes `byte_received`/`received_data` and drives `data_to_send`.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops on each of `sck`, `mosi`, `ssel` (min 2).
- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  asynchronous, active-low reset (asserted at 0).
- `sck`  input  1  SPI clock from host, asynchronous to `clk`.
- `mosi`  input  1  host-to-slave data.
- `ssel`  input  1  slave select, active low.
- `miso`  output  1  slave-to-host data.
- `byte_received`  output  1  one-`clk` pulse: `received_data` holds a new byte.
- `received_data`  output  8  last completed MOSI byte; held until the next byte completes.
- `data_needed`  output  1  one-`clk` pulse: `data_to_send` was just loaded into the TX shifter, so upstream may present the next byte.
- `data_to_send`  input  8  next byte to transmit; sampled only at TX load.
- `frame_active`  output  1  synchronized `ssel` asserted.
- `frame_err`  output  1  sticky: `ssel` deasserted with a partial byte; cleared at the next `ssel` assertion.

## Operation
- SPI mode 0 (CPOL=0, CPHA=0), MSB first.
  - MOSI is sampled on SCK rise.
  - MISO changes on SCK fall.
- Synchronization and edge detection:
  - `sck`, `mosi` and `ssel` each pass through `SYNC_STAGES` flops plus one history flop.
  - Rise, fall and select/deselect edges are decoded from the last two flops.
  - `mosi` uses the same depth as `sck`, so the sampled bit is MOSI at the SCK rise.
- Receive path:
  - A 3-bit `bit_cnt` and a 7-bit RX shift register (`rx_sr`) are used.
  - On each SCK rise while selected, the sampled MOSI bit shifts into `rx_sr` and `bit_cnt` increments.
  - On the rise where `bit_cnt`==7: `received_data` <= {`rx_sr`, mosi}, `byte_received` pulses for one cycle, and `bit_cnt` wraps to 0.
- Transmit path:
  - TX shift register `tx_sr`, 8 bits; `miso` = `tx_sr`[7] while selected, else 0.
  - Load `tx_sr` <= `data_to_send` and pulse `data_needed` in two cases:
    - the cycle after the `ssel` assert edge is detected;
    - the SCK fall following a `byte_received` (the fall ending bit 7).
  - On any other SCK fall while selected, shift `tx_sr` left by one with 0 fill.
- Deselect:
  - On the `ssel` rising edge, `bit_cnt` and `rx_sr` clear and `frame_active` drops.
  - If `bit_cnt`!=0 at that edge, set `frame_err`; no `byte_received` is issued for the partial byte.
  - SCK edges while deselected are ignored.
- Simultaneous events: a deselect edge takes priority over an SCK edge decoded in the same cycle (the SCK edge is dropped).
- Reset (async, any time, including mid-frame) returns all outputs to their reset values. After reset release, the first byte is only recognized after a fresh `ssel` assert edge.
- No internal state machine beyond IDLE (deselected) / ACTIVE (selected), tracked by the synchronized `ssel`.

## Timing
- Reset values:
  - `miso`=0, `byte_received`=0, `received_data`=8'h00, `data_needed`=0, `frame_active`=0, `frame_err`=0.
  - `tx_sr`=0, `bit_cnt`=0.
- Pin-to-pulse latency: `byte_received` asserts `SYNC_STAGES`+2 `clk` cycles after the 8th SCK rise is first sampled (2 sync + detect + registered output = 4 with the default).
- `frame_active` follows `ssel` with the same latency.
- `data_needed` and the TX load happen `SYNC_STAGES`+2 cycles after the corresponding SCK fall or `ssel` edge.
- Upstream may update `data_to_send` on the cycle after `byte_received`. It must be stable by the next SCK fall.
- Requirement: f_clk >= 8 x f_sck. Also, the host leaves >= `SYNC_STAGES`+3 `clk` cycles between `ssel` assertion and the first SCK rise.
- Back-to-back bytes without gaps are supported. `byte_received` pulses are exactly 8 SCK periods apart.

## Test plan
- Reset: hold `reset`=0 with random pins -> all outputs at reset values. Release with `ssel`=1 -> no pulses.
- Single byte: `data_to_send`=8'hA0, assert `ssel`, send 8'hA2 -> MISO bits 1,0,1,0,0,0,0,0 on successive rises; one `byte_received` with `received_data`=8'hA2, 4 cycles after the 8th rise.
- Stream: 76 back-to-back bytes 8'h00..8'h4B with f_clk=8 x f_sck. The bench updates `data_to_send` to byte count+1 after each `byte_received` -> 76 pulses in order; MISO byte k equals the value presented after pulse k-1; 77 `data_needed` pulses.
- Partial abort: 5 SCK cycles, then deselect -> no `byte_received`, `frame_err`=1. Next `ssel` assertion clears it; the following full byte 8'h5A is received correctly.
- Reset mid-byte: assert `reset`=0 after 3 bits -> outputs reset immediately. After release and reselect, a full byte 8'hC3 is received with no residue from the aborted bits.
- Deselected SCK: toggle SCK 16 times with `ssel`=1 -> no `byte_received`, no `data_needed`, `miso`=0.

Source files
------------

// File: rtl/spi_byte_slave.sv
`default_nettype none
// ============================================================================
//  Module   : spi_byte_slave
//  Purpose  : SPI mode-0 (CPOL=0, CPHA=0, MSB first) byte slave. SCK, MOSI
//             and SSEL are oversampled in the clk domain; completed MOSI bytes
//             are presented with a one-cycle byte_received pulse, and the byte
//             on data_to_send is shifted out on MISO.
//  Ports    : clk           - system clock, rising edge
//             reset         - asynchronous reset, active low
//             sck/mosi/ssel - SPI pins from the host (async to clk, ssel low)
//             miso          - SPI data to the host (0 while deselected)
//             byte_received - 1-cycle pulse, received_data holds a new byte
//             received_data - last completed MOSI byte
//             data_needed   - 1-cycle pulse, data_to_send was just loaded
//             data_to_send  - next byte to transmit, sampled at TX load only
//             frame_active  - synchronized ssel is asserted
//             frame_err     - sticky, frame ended on a partial byte
//  Revision : 1.0 - initial release
// ============================================================================
module spi_byte_slave #(
   parameter int SYNC_STAGES = 2   // synchronizer depth, must be >= 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sck,
   input  logic       mosi,
   input  logic       ssel,
   output logic       miso,
   output logic       byte_received,
   output logic [7:0] received_data,
   output logic       data_needed,
   input  logic [7:0] data_to_send,
   output logic       frame_active,
   output logic       frame_err
);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_e;

   // Synchronizer chains: bits [SYNC_STAGES-1:0] synchronize, bit
   // [SYNC_STAGES] is the history flop used for edge decoding.
   logic [SYNC_STAGES:0] sck_sync_q;
   logic [SYNC_STAGES:0] mosi_sync_q;
   logic [SYNC_STAGES:0] ssel_sync_q;

   // Registered edge events
   logic sck_rise_q;
   logic sck_fall_q;
   logic sel_assert_q;
   logic sel_deassert_q;

   // Edge decode from the last two flops of each chain
   logic sck_rise_d;
   logic sck_fall_d;
   logic sel_assert_d;
   logic sel_deassert_d;
   logic mosi_bit;

   // Frame / datapath state
   state_e     state_q;
   logic [2:0] bit_cnt_q;
   logic [6:0] rx_sr_q;
   logic [7:0] tx_sr_q;
   logic [7:0] received_data_q;
   logic       byte_received_q;
   logic       data_needed_q;
   logic       frame_err_q;
   logic       load_pending_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sck_sync_q  <= '0;
         mosi_sync_q <= '0;
         // Resetting ssel to "asserted" means a select held low through reset
         // release produces no assert edge: only a fresh assertion opens a frame.
         ssel_sync_q <= '0;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-1:0], sck};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-1:0], mosi};
         ssel_sync_q <= {ssel_sync_q[SYNC_STAGES-1:0], ssel};
      end
   end

   assign sck_rise_d     =  sck_sync_q[SYNC_STAGES-1]  & ~sck_sync_q[SYNC_STAGES];
   assign sck_fall_d     = ~sck_sync_q[SYNC_STAGES-1]  &  sck_sync_q[SYNC_STAGES];
   assign sel_assert_d   = ~ssel_sync_q[SYNC_STAGES-1] &  ssel_sync_q[SYNC_STAGES];
   assign sel_deassert_d =  ssel_sync_q[SYNC_STAGES-1] & ~ssel_sync_q[SYNC_STAGES];

   // The MOSI history flop is loaded on the same clk edge as sck_rise_q, so
   // while sck_rise_q is high it holds MOSI as it was at the SCK rise.
   assign mosi_bit = mosi_sync_q[SYNC_STAGES];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sck_rise_q     <= 1'b0;
         sck_fall_q     <= 1'b0;
         sel_assert_q   <= 1'b0;
         sel_deassert_q <= 1'b0;
      end else begin
         sck_rise_q     <= sck_rise_d;
         sck_fall_q     <= sck_fall_d;
         sel_assert_q   <= sel_assert_d;
         sel_deassert_q <= sel_deassert_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= ST_IDLE;
         bit_cnt_q       <= 3'd0;
         rx_sr_q         <= 7'd0;
         tx_sr_q         <= 8'd0;
         received_data_q <= 8'd0;
         byte_received_q <= 1'b0;
         data_needed_q   <= 1'b0;
         frame_err_q     <= 1'b0;
         load_pending_q  <= 1'b0;
      end else begin
         byte_received_q <= 1'b0;
         data_needed_q   <= 1'b0;

         // Deselect wins over any SCK edge decoded in the same cycle
         if (sel_deassert_q) begin
            state_q        <= ST_IDLE;
            bit_cnt_q      <= 3'd0;
            rx_sr_q        <= 7'd0;
            load_pending_q <= 1'b0;
            if (bit_cnt_q != 3'd0) begin
               frame_err_q <= 1'b1;
            end
         end else if (sel_assert_q) begin
            state_q        <= ST_ACTIVE;
            bit_cnt_q      <= 3'd0;
            rx_sr_q        <= 7'd0;
            frame_err_q    <= 1'b0;
            load_pending_q <= 1'b0;
            tx_sr_q        <= data_to_send;
            data_needed_q  <= 1'b1;
         end else if (state_q == ST_ACTIVE) begin
            if (sck_rise_q) begin
               rx_sr_q   <= {rx_sr_q[5:0], mosi_bit};
               bit_cnt_q <= bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  received_data_q <= {rx_sr_q, mosi_bit};
                  byte_received_q <= 1'b1;
                  load_pending_q  <= 1'b1;
               end
            end
            if (sck_fall_q) begin
               // The fall that ends bit 7 starts the next byte from upstream
               if (load_pending_q) begin
                  tx_sr_q        <= data_to_send;
                  data_needed_q  <= 1'b1;
                  load_pending_q <= 1'b0;
               end else begin
                  tx_sr_q <= {tx_sr_q[6:0], 1'b0};
               end
            end
         end
      end
   end

   assign miso          = (state_q == ST_ACTIVE) & tx_sr_q[7];
   assign byte_received = byte_received_q;
   assign received_data = received_data_q;
   assign data_needed   = data_needed_q;
   assign frame_active  = (state_q == ST_ACTIVE);
   assign frame_err     = frame_err_q;

endmodule
`default_nettype wire
